// File: rtl/uart_loader_ctrl.sv
// uart_loader_ctrl
//   Sequences a program download arriving over the UART receive byte stream.
//   Packet: HDR_BYTE, addr[15:8], addr[7:0], len[15:8], len[7:0],
//           len x {data[15:8], data[7:0]}, checksum (8-bit sum of all bytes
//           after the header, excluding the checksum byte itself).
//   Each word becomes one memory write through a req/ack handshake with an
//   auto-incrementing (wrapping) word address. The CPU is held in reset while
//   a packet is in progress; a one-byte status goes back to the PC at the end:
//   8'hA5 OK, 8'hE1 checksum mismatch, 8'hE2 overrun, 8'hE3 timeout.
//
//   Optional build macro LOADER_TIMEOUT_EN: aborts a stalled packet after
//   TIMEOUT_CYC idle clock cycles between bytes.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   rx_byte_i, rx_valid_i   received byte and its one-cycle valid pulse
//   mem_req_o, mem_addr_o,
//   mem_wdata_o, mem_ack_i  memory write handshake (req held until ack)
//   tx_byte_o, tx_start_o,
//   tx_busy_i               status byte to the UART transmitter
//   cpu_rst_o               CPU hold-in-reset
//   busy_o                  packet in progress (state other than idle)
module uart_loader_ctrl #(
    parameter int unsigned ADDR_W      = 16,
    parameter logic [7:0]  HDR_BYTE    = 8'h80,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        rx_byte_i,
    input  logic              rx_valid_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [15:0]       mem_wdata_o,
    input  logic              mem_ack_i,
    output logic [7:0]        tx_byte_o,
    output logic              tx_start_o,
    input  logic              tx_busy_i,
    output logic              cpu_rst_o,
    output logic              busy_o
);

    typedef enum logic [3:0] {
        StIdle, StAddrH, StAddrL, StLenH, StLenL, StDataH, StDataL, StCsum, StResp
    } state_t;

    state_t            state_q;
    logic [7:0]        hi_q;        // high byte of the field being assembled
    logic [7:0]        csum_q;
    logic [15:0]       len_q;       // words still to receive
    logic [ADDR_W-1:0] addr_q;      // address of the next word
    logic              ovr_q;
    logic              cerr_q;
    logic              csum_seen_q; // checksum byte consumed; waiting for last ack
`ifdef LOADER_TIMEOUT_EN
    logic [31:0]       tmo_cnt_q;
    logic              tmo_q;
`endif

    logic [15:0] rx_word;
    logic [7:0]  status;

    assign rx_word = {hi_q, rx_byte_i};
    assign busy_o  = (state_q != StIdle);

    always_comb begin
        status = 8'hA5;
        if (cerr_q) status = 8'hE1;
        if (ovr_q)  status = 8'hE2;
`ifdef LOADER_TIMEOUT_EN
        if (tmo_q)  status = 8'hE3;
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            hi_q        <= 8'h00;
            csum_q      <= 8'h00;
            len_q       <= 16'h0000;
            addr_q      <= '0;
            ovr_q       <= 1'b0;
            cerr_q      <= 1'b0;
            csum_seen_q <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= 16'h0000;
            tx_byte_o   <= 8'h00;
            tx_start_o  <= 1'b0;
            cpu_rst_o   <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
            tmo_cnt_q   <= 32'd0;
            tmo_q       <= 1'b0;
`endif
        end else begin
            tx_start_o <= 1'b0;
            if (mem_req_o && mem_ack_i) mem_req_o <= 1'b0;

            // Running sum covers every byte between header and checksum.
            if (rx_valid_i && state_q != StIdle && state_q != StCsum && state_q != StResp) begin
                csum_q <= csum_q + rx_byte_i;
            end

            unique case (state_q)
                StIdle: begin
                    if (rx_valid_i && rx_byte_i == HDR_BYTE) begin
                        state_q     <= StAddrH;
                        csum_q      <= 8'h00;
                        ovr_q       <= 1'b0;
                        cerr_q      <= 1'b0;
                        csum_seen_q <= 1'b0;
                        cpu_rst_o   <= 1'b1;
`ifdef LOADER_TIMEOUT_EN
                        tmo_q       <= 1'b0;
`endif
                    end
                end
                StAddrH: if (rx_valid_i) begin
                    hi_q    <= rx_byte_i;
                    state_q <= StAddrL;
                end
                StAddrL: if (rx_valid_i) begin
                    addr_q  <= ADDR_W'(rx_word);
                    state_q <= StLenH;
                end
                StLenH: if (rx_valid_i) begin
                    hi_q    <= rx_byte_i;
                    state_q <= StLenL;
                end
                StLenL: if (rx_valid_i) begin
                    len_q   <= rx_word;
                    state_q <= (rx_word == 16'h0000) ? StCsum : StDataH;
                end
                StDataH: if (rx_valid_i) begin
                    hi_q    <= rx_byte_i;
                    state_q <= StDataL;
                end
                StDataL: if (rx_valid_i) begin
                    // A write slot is free if idle or being acked right now.
                    if (!mem_req_o || mem_ack_i) begin
                        mem_req_o   <= 1'b1;
                        mem_addr_o  <= addr_q;
                        mem_wdata_o <= rx_word;
                    end else begin
                        ovr_q <= 1'b1;
                    end
                    addr_q  <= addr_q + 1'b1;
                    len_q   <= len_q - 16'd1;
                    state_q <= (len_q == 16'd1) ? StCsum : StDataH;
                end
                StCsum: begin
                    if (!csum_seen_q && rx_valid_i) begin
                        csum_seen_q <= 1'b1;
                        if (rx_byte_i != csum_q) cerr_q <= 1'b1;
                        if (!mem_req_o) state_q <= StResp;
                    end else if (csum_seen_q && !mem_req_o) begin
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    // Pulse first, release the CPU on the following cycle.
                    if (tx_start_o) begin
                        cpu_rst_o <= 1'b0;
                        state_q   <= StIdle;
                    end else if (!tx_busy_i) begin
                        tx_start_o <= 1'b1;
                        tx_byte_o  <= status;
                    end
                end
                default: state_q <= StIdle;
            endcase

`ifdef LOADER_TIMEOUT_EN
            if (rx_valid_i) begin
                tmo_cnt_q <= 32'd0;
            end else if (state_q != StIdle && state_q != StResp && !tmo_q) begin
                if (tmo_cnt_q == 32'(TIMEOUT_CYC - 1)) begin
                    // Reuse the checksum wait to let a pending write finish.
                    tmo_q       <= 1'b1;
                    csum_seen_q <= 1'b1;
                    state_q     <= StCsum;
                    tmo_cnt_q   <= 32'd0;
                end else begin
                    tmo_cnt_q <= tmo_cnt_q + 32'd1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_uart_loader_ctrl.sv
// Self-checking bench for uart_loader_ctrl (default build, ADDR_W=16).
module tb_uart_loader_ctrl;

    typedef logic [7:0] bq_t[$];

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [7:0]  rx_byte_i;
    logic        rx_valid_i;
    logic        mem_req_o;
    logic [15:0] mem_addr_o;
    logic [15:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [7:0]  tx_byte_o;
    logic        tx_start_o;
    logic        tx_busy_i;
    logic        cpu_rst_o;
    logic        busy_o;

    uart_loader_ctrl dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rx_byte_i   (rx_byte_i),
        .rx_valid_i  (rx_valid_i),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .tx_byte_o   (tx_byte_o),
        .tx_start_o  (tx_start_o),
        .tx_busy_i   (tx_busy_i),
        .cpu_rst_o   (cpu_rst_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int          tests = 0;
    int          fails = 0;
    logic        ack_en = 1'b1;
    logic [31:0] got_w[$];
    logic [7:0]  got_tx[$];
    logic        tx_cpu[$];
    logic [31:0] exp_w[$];
    logic [7:0]  exp_st;

    // Memory/transmitter side: ack any pending request when enabled and log
    // accepted writes and status bytes.
    initial begin
        mem_ack_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (mem_req_o && ack_en) begin
                got_w.push_back({mem_addr_o, mem_wdata_o});
                mem_ack_i = 1'b1;
            end else begin
                mem_ack_i = 1'b0;
            end
            if (tx_start_o) begin
                got_tx.push_back(tx_byte_o);
                tx_cpu.push_back(cpu_rst_o);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] sum_after_hdr(input bq_t p);
        logic [7:0] s = 8'h00;
        for (int i = 1; i < p.size(); i++) s = s + p[i];
        return s;
    endfunction

    // Reference: all writes accepted (immediate ack), address wraps at 16 bits.
    task automatic model(input bq_t p);
        logic [15:0] a, n;
        logic [7:0]  s = 8'h00;
        a = {p[1], p[2]};
        n = {p[3], p[4]};
        exp_w.delete();
        for (int i = 0; i < int'(n); i++) begin
            exp_w.push_back({a + 16'(i), p[5 + 2 * i], p[6 + 2 * i]});
        end
        for (int i = 1; i < p.size() - 1; i++) s = s + p[i];
        exp_st = (s == p[p.size() - 1]) ? 8'hA5 : 8'hE1;
    endtask

    // Called at posedge+1; returns at posedge+1.
    task automatic send_byte(input logic [7:0] b);
        rx_byte_i  = b;
        rx_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        rx_valid_i = 1'b0;
        rx_byte_i  = 8'($urandom);
    endtask

    task automatic send_pkt(input bq_t p, input string tag);
        for (int i = 0; i < p.size(); i++) begin
            send_byte(p[i]);
            if (i == 0) begin
                check({tag, "/cpu_rst_after_hdr"}, 32'(cpu_rst_o), 32'd1);
                check({tag, "/busy_after_hdr"}, 32'(busy_o), 32'd1);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk_i);
            #0;
        end
    endtask

    task automatic wait_tx();
        int n = 0;
        while (got_tx.size() == 0 && n < 3000) begin
            @(posedge clk_i);
            n++;
        end
        #1;
    endtask

    task automatic check_result(input string tag);
        check({tag, "/tx_count"}, 32'(got_tx.size()), 32'd1);
        check({tag, "/status"}, 32'(got_tx.size() > 0 ? got_tx[0] : 8'h00), 32'(exp_st));
        check({tag, "/cpu_rst_at_tx"}, 32'(tx_cpu.size() > 0 ? tx_cpu[0] : 1'b0), 32'd1);
        check({tag, "/write_count"}, 32'(got_w.size()), 32'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
            check($sformatf("%s/write%0d", tag, i), got_w[i], exp_w[i]);
        end
        repeat (3) @(posedge clk_i);
        #1;
        check({tag, "/cpu_rst_released"}, 32'(cpu_rst_o), 32'd0);
        check({tag, "/busy_end"}, 32'(busy_o), 32'd0);
    endtask

    task automatic run_pkt(input bq_t p, input string tag, input int busy_cycles);
        model(p);
        got_w.delete();
        got_tx.delete();
        tx_cpu.delete();
        if (busy_cycles > 0) tx_busy_i = 1'b1;
        send_pkt(p, tag);
        if (busy_cycles > 0) begin
            repeat (busy_cycles) @(posedge clk_i);
            #1;
            check({tag, "/no_tx_while_busy"}, 32'(got_tx.size()), 32'd0);
            tx_busy_i = 1'b0;
        end
        wait_tx();
        check_result(tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t p;
        logic [15:0] ln;
        rst_i      = 1'b1;
        rx_byte_i  = 8'h00;
        rx_valid_i = 1'b0;
        tx_busy_i  = 1'b0;
        #1;
        check("reset/mem_req", 32'(mem_req_o), 32'd0);
        check("reset/mem_addr", 32'(mem_addr_o), 32'd0);
        check("reset/mem_wdata", 32'(mem_wdata_o), 32'd0);
        check("reset/tx_start", 32'(tx_start_o), 32'd0);
        check("reset/tx_byte", 32'(tx_byte_o), 32'd0);
        check("reset/cpu_rst", 32'(cpu_rst_o), 32'd0);
        check("reset/busy", 32'(busy_o), 32'd0);
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Noise before the header is ignored.
        send_byte(8'h55);
        send_byte(8'hAA);
        check("noise/busy", 32'(busy_o), 32'd0);
        check("noise/cpu_rst", 32'(cpu_rst_o), 32'd0);

        // Two-word packet with a correct checksum; transmitter busy for a while.
        p = {8'h80, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        p.push_back(sum_after_hdr(p));
        run_pkt(p, "ok2", 20);

        // Same packet, wrong checksum: writes still happen.
        p = {8'h80, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00};
        run_pkt(p, "csum_bad", 0);

        // Zero length.
        p = {8'h80, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFE};
        run_pkt(p, "len0", 0);

        // Address wrap, header value inside the payload.
        p = {8'h80, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'h80, 8'h01, 8'h02, 8'h80};
        p.push_back(sum_after_hdr(p));
        run_pkt(p, "wrap", 0);

        // Overrun: no ack across two word completions.
        ack_en = 1'b0;
        got_w.delete();
        got_tx.delete();
        tx_cpu.delete();
        p = {8'h80, 8'h00, 8'h20, 8'h00, 8'h02, 8'h11, 8'h11, 8'h22, 8'h22};
        p.push_back(sum_after_hdr(p));
        send_pkt(p, "ovr");
        repeat (10) @(posedge clk_i);
        #1;
        check("ovr/no_tx_before_ack", 32'(got_tx.size()), 32'd0);
        check("ovr/req_held", 32'(mem_req_o), 32'd1);
        check("ovr/addr_stable", 32'(mem_addr_o), 32'h0020);
        check("ovr/wdata_stable", 32'(mem_wdata_o), 32'h1111);
        ack_en = 1'b1;
        exp_w.delete();
        exp_w.push_back(32'h0020_1111);
        exp_st = 8'hE2;
        wait_tx();
        check_result("ovr");

        // Reset in the middle of a packet with a write outstanding.
        ack_en = 1'b0;
        p = {8'h80, 8'h00, 8'h30, 8'h00, 8'h03, 8'h12, 8'h34};
        send_pkt(p, "midrst");
        #1;
        check("midrst/req_before", 32'(mem_req_o), 32'd1);
        #2;
        rst_i = 1'b1;
        #1;
        check("midrst/req", 32'(mem_req_o), 32'd0);
        check("midrst/addr", 32'(mem_addr_o), 32'd0);
        check("midrst/wdata", 32'(mem_wdata_o), 32'd0);
        check("midrst/cpu_rst", 32'(cpu_rst_o), 32'd0);
        check("midrst/busy", 32'(busy_o), 32'd0);
        check("midrst/tx_start", 32'(tx_start_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_i  = 1'b0;
        ack_en = 1'b1;
        @(posedge clk_i);
        #1;
        p = {8'h80, 8'h12, 8'h00, 8'h00, 8'h01, 8'hBE, 8'hEF};
        p.push_back(sum_after_hdr(p));
        run_pkt(p, "after_rst", 0);

        // Randomized packets against the reference model.
        for (int k = 0; k < 8; k++) begin
            ln = 16'($urandom_range(0, 4));
            p = {8'h80, 8'($urandom), 8'($urandom), ln[15:8], ln[7:0]};
            for (int i = 0; i < 2 * int'(ln); i++) p.push_back(8'($urandom));
            p.push_back(sum_after_hdr(p) ^ (($urandom_range(0, 3) == 0) ? 8'h5A : 8'h00));
            run_pkt(p, $sformatf("rand%0d", k), ($urandom_range(0, 1) == 1) ? 5 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
